// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
//   Shared definitions for the RAM arbiter: RAM word-address / data widths
//   and the arbiter state encoding.
// ---------------------------------------------------------------------------
package ram_pkg;

  localparam int unsigned RAM_AW = 22;
  localparam int unsigned RAM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_VID = 2'd1,
    ST_BUSY_CPU = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arb.sv
// ---------------------------------------------------------------------------
// ram_arb
//   Two-master arbiter in front of the RAM controller. The video refresh port
//   (read-only) and the CPU port (read/write) share one stb/we/addr/ack RAM
//   port. The grant is taken in IDLE, RAM stb is held from grant until ack,
//   and read data / ack are returned only to the master that owns the access.
//   On a simultaneous request the master that did not win last time is
//   served, so neither master waits more than one foreign access.
//
// Build option:
//   RAM_ARB_TIMEOUT_EN - when defined, an access with no ram_ack for
//                        TIMEOUT_CYC busy cycles is aborted: the owner gets
//                        ack with dout=0, and cpu_err=1 if the owner is CPU.
//                        When undefined, BUSY waits for ram_ack forever and
//                        cpu_err is always 0.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   vid_stb/vid_addr         video read request (held until vid_ack)
//   vid_dout/vid_ack         video read data / 1-cycle completion
//   cpu_stb/we/addr/din      CPU request (held until cpu_ack)
//   cpu_dout/cpu_ack/cpu_err CPU read data / completion / timeout abort
//   ram_stb/we/addr/din      registered RAM request
//   ram_dout/ram_ack         RAM read data / completion
// ---------------------------------------------------------------------------
module ram_arb
  import ram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_stb,
  input  logic [RAM_AW-1:0] vid_addr,
  output logic [RAM_DW-1:0] vid_dout,
  output logic              vid_ack,
  input  logic              cpu_stb,
  input  logic              cpu_we,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [RAM_DW-1:0] cpu_din,
  output logic [RAM_DW-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              ram_stb,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_din,
  input  logic [RAM_DW-1:0] ram_dout,
  input  logic              ram_ack
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("ram_arb: TIMEOUT_CYC must be at least 2");
  end

  state_t              r_state;
  state_t              w_next;
  logic                r_last_vid;
  logic                r_ram_stb;
  logic                r_ram_we;
  logic [RAM_AW-1:0]   r_ram_addr;
  logic [RAM_DW-1:0]   r_ram_din;

  logic                w_grant_vid;
  logic                w_grant_cpu;
  logic                w_busy_vid;
  logic                w_busy_cpu;
  logic                w_timeout;
  logic                w_done;

  // Video wins a tie unless it won the previous grant.
  assign w_grant_vid = vid_stb & (~cpu_stb | ~r_last_vid);
  assign w_grant_cpu = cpu_stb & ~w_grant_vid;

  assign w_busy_vid  = (r_state == ST_BUSY_VID);
  assign w_busy_cpu  = (r_state == ST_BUSY_CPU);

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] r_tmo_cnt;

  // Counter sits at 0 in IDLE, so it is already cleared on entry to BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state != ST_IDLE) & ~ram_ack &
                     (r_tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done = ram_ack | w_timeout;

  // Acks are combinational from ram_ack, gated by ownership; ram_ack in IDLE
  // is ignored. On a timeout abort ram_ack is 0, so dout reads as 0.
  assign vid_ack  = w_busy_vid & w_done;
  assign cpu_ack  = w_busy_cpu & w_done;
  assign cpu_err  = w_busy_cpu & w_timeout;
  assign vid_dout = (w_busy_vid & ram_ack) ? ram_dout : '0;
  assign cpu_dout = (w_busy_cpu & ram_ack) ? ram_dout : '0;

  assign ram_stb  = r_ram_stb;
  assign ram_we   = r_ram_we;
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vid) begin
          w_next = ST_BUSY_VID;
        end else if (w_grant_cpu) begin
          w_next = ST_BUSY_CPU;
        end
      end
      ST_BUSY_VID, ST_BUSY_CPU: begin
        if (w_done) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_last_vid <= 1'b0;
      r_ram_stb  <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vid) begin
            r_ram_stb  <= 1'b1;
            r_ram_we   <= 1'b0;
            r_ram_addr <= vid_addr;
            r_ram_din  <= '0;
            r_last_vid <= 1'b1;
          end else if (w_grant_cpu) begin
            r_ram_stb  <= 1'b1;
            r_ram_we   <= cpu_we;
            r_ram_addr <= cpu_addr;
            r_ram_din  <= cpu_din;
            r_last_vid <= 1'b0;
          end
        end
        ST_BUSY_VID, ST_BUSY_CPU: begin
          if (w_done) begin
            r_ram_stb <= 1'b0;
          end
        end
        default: r_ram_stb <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
module tb_ram_arb;
  import ram_pkg::*;

  localparam int TMO   = 32;
  localparam int LIMIT = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              vid_stb = 1'b0;
  logic [RAM_AW-1:0] vid_addr = '0;
  logic [RAM_DW-1:0] vid_dout;
  logic              vid_ack;
  logic              cpu_stb = 1'b0;
  logic              cpu_we = 1'b0;
  logic [RAM_AW-1:0] cpu_addr = '0;
  logic [RAM_DW-1:0] cpu_din = '0;
  logic [RAM_DW-1:0] cpu_dout;
  logic              cpu_ack;
  logic              cpu_err;
  logic              ram_stb;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [RAM_DW-1:0] ram_din;
  logic [RAM_DW-1:0] ram_dout;
  logic              ram_ack;

  always #5 clk = ~clk;

  ram_arb #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .vid_stb(vid_stb), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
    .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .ram_stb(ram_stb), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_ack(ram_ack)
  );

  // RAM model: 256 words indexed by addr[7:0], preloaded with 0xC0DE00xx.
  // Ack is a 1-cycle pulse in the ram_cyc-th cycle of ram_stb.
  logic [31:0] mem [0:255];
  int          ram_cyc = 2;
  int          ram_cnt = 0;
  logic        noack = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
  end

  assign ram_ack  = ram_stb && (ram_cnt == ram_cyc - 1) && !noack;
  assign ram_dout = mem[ram_addr[7:0]];

  always @(posedge clk) begin
    if (!ram_stb || ram_ack) ram_cnt <= 0;
    else                     ram_cnt <= ram_cnt + 1;
    if (ram_ack && ram_we) mem[ram_addr[7:0]] <= ram_din;
  end

  // Scoreboard
  typedef struct { logic [31:0] data; logic chk_d; logic err; } cpu_exp_t;
  typedef struct { logic we; logic [21:0] addr; logic [31:0] din; } gnt_t;

  logic [31:0] vid_q [$];
  cpu_exp_t    cpu_q [$];
  gnt_t        gnt_q [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred, required absent (t=%0t)", name, $time);
  endtask

  // Monitor
  logic        prev_stb = 1'b0;
  logic [21:0] prev_addr = '0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_din = '0;

  always @(negedge clk) begin
    if (vid_ack && cpu_ack) fail_evt("both_acks");
    if (vid_ack) begin
      if (vid_q.size() == 0) fail_evt("vid_ack_unexpected");
      else chk("vid_dout", 64'(vid_dout), 64'(vid_q.pop_front()));
    end
    if (cpu_ack) begin
      if (cpu_q.size() == 0) fail_evt("cpu_ack_unexpected");
      else begin
        cpu_exp_t e;
        e = cpu_q.pop_front();
        chk("cpu_err", 64'(cpu_err), 64'(e.err));
        if (e.chk_d) chk("cpu_dout", 64'(cpu_dout), 64'(e.data));
      end
    end
    if (ram_stb && !prev_stb) begin
      if (gnt_q.size() == 0) fail_evt("grant_unexpected");
      else begin
        gnt_t g;
        g = gnt_q.pop_front();
        chk("grant_we", 64'(ram_we), 64'(g.we));
        chk("grant_addr", 64'(ram_addr), 64'(g.addr));
        chk("grant_din", 64'(ram_din), 64'(g.din));
      end
    end else if (ram_stb && prev_stb) begin
      chk("ram_stable", {ram_we, ram_addr, ram_din}, {prev_we, prev_addr, prev_din});
    end
    prev_stb  = ram_stb;
    prev_addr = ram_addr;
    prev_we   = ram_we;
    prev_din  = ram_din;
  end

  // Drivers
  task automatic cpu_xfer(input logic we, input logic [21:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input logic chk_d, input logic exp_err,
                          output int lat);
    cpu_exp_t e;
    @(posedge clk); #1;
    e.data = exp; e.chk_d = chk_d; e.err = exp_err;
    cpu_q.push_back(e);
    cpu_we = we; cpu_addr = a; cpu_din = d; cpu_stb = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!cpu_ack && lat < LIMIT);
    if (!cpu_ack) fail_evt("cpu_ack_timeout");
    @(posedge clk); #1;
    cpu_stb = 1'b0;
  endtask

  task automatic vid_xfer(input logic [21:0] a, input logic [31:0] exp,
                          input logic first, input logic last);
    int n;
    if (first) begin @(posedge clk); #1; end
    vid_q.push_back(exp);
    vid_addr = a; vid_stb = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!vid_ack && n < LIMIT);
    if (!vid_ack) fail_evt("vid_ack_timeout");
    @(posedge clk); #1;
    if (last) vid_stb = 1'b0;
  endtask

  task automatic push_gnt(input logic we, input logic [21:0] a, input logic [31:0] d);
    gnt_t g;
    g.we = we; g.addr = a; g.din = d;
    gnt_q.push_back(g);
  endtask

  int lat;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ram_stb", 64'(ram_stb), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_din", 64'(ram_din), 64'd0);
    chk("rst_acks", {vid_ack, cpu_ack, cpu_err}, 64'd0);
    chk("rst_douts", {vid_dout, cpu_dout}, 64'd0);
    rst = 1'b1;

    // 1: CPU write then read back, 2-cycle RAM
    push_gnt(1'b1, 22'h000100, 32'h12345678);
    push_gnt(1'b0, 22'h000100, 32'h0);
    cpu_xfer(1'b1, 22'h000100, 32'h12345678, 32'h0, 1'b0, 1'b0, lat);
    chk("lat_wr_2cyc", 64'(lat), 64'd3);
    cpu_xfer(1'b0, 22'h000100, 32'h0, 32'h12345678, 1'b1, 1'b0, lat);
    chk("lat_rd_2cyc", 64'(lat), 64'd3);

    // 2: ties and alternation
    push_gnt(1'b0, 22'h000040, 32'h0);
    push_gnt(1'b0, 22'h000041, 32'h0);
    fork
      vid_xfer(22'h000040, 32'hC0DE0040, 1'b1, 1'b1);
      cpu_xfer(1'b0, 22'h000041, 32'h0, 32'hC0DE0041, 1'b1, 1'b0, lat);
    join
    push_gnt(1'b0, 22'h000044, 32'h0);
    push_gnt(1'b0, 22'h000045, 32'h0);
    fork
      vid_xfer(22'h000044, 32'hC0DE0044, 1'b1, 1'b1);
      cpu_xfer(1'b0, 22'h000045, 32'h0, 32'hC0DE0045, 1'b1, 1'b0, lat);
    join
    push_gnt(1'b0, 22'h000042, 32'h0);
    vid_xfer(22'h000042, 32'hC0DE0042, 1'b1, 1'b1);
    push_gnt(1'b0, 22'h000043, 32'h0);
    push_gnt(1'b0, 22'h000046, 32'h0);
    fork
      vid_xfer(22'h000046, 32'hC0DE0046, 1'b1, 1'b1);
      cpu_xfer(1'b0, 22'h000043, 32'h0, 32'hC0DE0043, 1'b1, 1'b0, lat);
    join

    // 3: continuous video stream with a CPU request, 14-cycle RAM
    ram_cyc = 14;
    push_gnt(1'b0, 22'h000010, 32'h0);
    push_gnt(1'b0, 22'h000055, 32'h0);
    push_gnt(1'b0, 22'h000020, 32'h0);
    push_gnt(1'b0, 22'h000030, 32'h0);
    fork
      begin
        vid_xfer(22'h000010, 32'hC0DE0010, 1'b1, 1'b0);
        vid_xfer(22'h000020, 32'hC0DE0020, 1'b0, 1'b0);
        vid_xfer(22'h000030, 32'hC0DE0030, 1'b0, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        cpu_xfer(1'b0, 22'h000055, 32'h0, 32'hC0DE0055, 1'b1, 1'b0, lat);
      end
    join

    // 4: reset in the middle of a CPU read
    push_gnt(1'b0, 22'h000077, 32'h0);
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 22'h000077; cpu_stb = 1'b1;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_ram_stb", 64'(ram_stb), 64'd0);
    chk("midrst_ram_addr", 64'(ram_addr), 64'd0);
    chk("midrst_cpu_ack", 64'(cpu_ack), 64'd0);
    cpu_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ram_cyc = 2;
    push_gnt(1'b0, 22'h000050, 32'h0);
    push_gnt(1'b0, 22'h000051, 32'h0);
    fork
      vid_xfer(22'h000050, 32'hC0DE0050, 1'b1, 1'b1);
      cpu_xfer(1'b0, 22'h000051, 32'h0, 32'hC0DE0051, 1'b1, 1'b0, lat);
    join
    ram_cyc = 14;
    push_gnt(1'b0, 22'h3FFFFF, 32'h0);
    cpu_xfer(1'b0, 22'h3FFFFF, 32'h0, 32'hC0DE00FF, 1'b1, 1'b0, lat);
    chk("lat_rd_14cyc", 64'(lat), 64'd15);

`ifdef RAM_ARB_TIMEOUT_EN
    // 5: RAM never acks -> abort with error, then a normal access
    noack = 1'b1;
    push_gnt(1'b0, 22'h000060, 32'h0);
    cpu_xfer(1'b0, 22'h000060, 32'h0, 32'h0, 1'b1, 1'b1, lat);
    chk("lat_timeout", 64'(lat), 64'(TMO + 1));
    noack = 1'b0;
    ram_cyc = 2;
    push_gnt(1'b0, 22'h000061, 32'h0);
    cpu_xfer(1'b0, 22'h000061, 32'h0, 32'hC0DE0061, 1'b1, 1'b0, lat);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("vid_q_drained", 64'(vid_q.size()), 64'd0);
    chk("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
    chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
